// File: rtl/mult_share_arb.sv
// Round-robin arbiter/sequencer sharing one non-pipelined multiplier between R requesters,
// with a watchdog that ends a job when the multiplier never answers.
module mult_share_arb #(
  parameter int N   = 8,
  parameter int M   = 4,
  parameter int R   = 4,
  parameter int TMO = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [R-1:0]     req,
  input  logic [R*N-1:0]   a_in,
  input  logic [R*M-1:0]   b_in,
  output logic [R-1:0]     ack,
  output logic [R-1:0]     done,
  output logic             err,
  output logic [M+N-1:0]   res_out,
  output logic             busy,
  output logic             mul_data_rdy,
  output logic [N-1:0]     mul_mult1,
  output logic [M-1:0]     mul_mult2,
  input  logic             mul_res_rdy,
  input  logic [M+N-1:0]   mul_res
);

  localparam int PW = (R > 1) ? $clog2(R) : 1;
  localparam int CW = $clog2(TMO + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d, owner_q, owner_d, win;
  logic             found;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [R-1:0]     ack_q, ack_d, done_q, done_d;
  logic             err_q, err_d, busy_q, drdy_q, drdy_d;
  logic [M+N-1:0]   res_q, res_d;
  logic [N-1:0]     m1_q, m1_d;
  logic [M-1:0]     m2_q, m2_d;

  function automatic logic [R-1:0] onehot(input logic [PW-1:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Search starts just after the last winner so priority rotates.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= R; k++) begin
      if (!found && req[(int'(ptr_q) + k) % R]) begin
        found = 1'b1;
        win   = PW'((int'(ptr_q) + k) % R);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    done_d  = '0;
    err_d   = 1'b0;
    drdy_d  = 1'b0;
    res_d   = res_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          m1_d    = a_in[int'(win)*N +: N];
          m2_d    = b_in[int'(win)*M +: M];
          ack_d   = onehot(win);
          drdy_d  = 1'b1;
          owner_d = win;
          ptr_d   = win;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A result arriving on the expiry cycle wins over the timeout.
        if (mul_res_rdy) begin
          res_d   = mul_res;
          done_d  = onehot(owner_q);
          state_d = DRAIN;
        end else if (cnt_q == CW'(TMO - 1)) begin
          res_d   = '0;
          done_d  = onehot(owner_q);
          err_d   = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!mul_res_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= PW'(R - 1);
      owner_q <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      drdy_q  <= 1'b0;
      res_q   <= '0;
      m1_q    <= '0;
      m2_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= (state_d != IDLE);
      drdy_q  <= drdy_d;
      res_q   <= res_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
    end
  end

  assign ack          = ack_q;
  assign done         = done_q;
  assign err          = err_q;
  assign res_out      = res_q;
  assign busy         = busy_q;
  assign mul_data_rdy = drdy_q;
  assign mul_mult1    = m1_q;
  assign mul_mult2    = m2_q;

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb with a behavioural multiplier stub of configurable
// latency, result hold time, and a dead mode that never answers.
module tb_mult_share_arb;
  localparam int N = 8, M = 4, R = 4, TMO = 64;

  logic           clk = 1'b0;
  logic           rstn;
  logic [R-1:0]   req;
  logic [R*N-1:0] a_in;
  logic [R*M-1:0] b_in;
  logic [R-1:0]   ack, done;
  logic           err, busy, mul_data_rdy, mul_res_rdy;
  logic [M+N-1:0] res_out, mul_res;
  logic [N-1:0]   mul_mult1;
  logic [M-1:0]   mul_mult2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mult_share_arb #(.N(N), .M(M), .R(R), .TMO(TMO)) dut (
    .clk(clk), .rstn(rstn), .req(req), .a_in(a_in), .b_in(b_in),
    .ack(ack), .done(done), .err(err), .res_out(res_out), .busy(busy),
    .mul_data_rdy(mul_data_rdy), .mul_mult1(mul_mult1), .mul_mult2(mul_mult2),
    .mul_res_rdy(mul_res_rdy), .mul_res(mul_res)
  );

  // Multiplier stub: product appears stub_lat cycles after data_rdy, held for stub_hold cycles.
  int             stub_lat = 1;
  int             stub_hold = 1;
  bit             stub_dead = 1'b0;
  int             st_cnt, st_hold;
  bit             st_pend;
  logic [M+N-1:0] st_prod;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mul_res_rdy <= 1'b0;
      mul_res     <= '0;
      st_pend     <= 1'b0;
      st_cnt      <= 0;
      st_hold     <= 0;
      st_prod     <= '0;
    end else if (mul_data_rdy && !stub_dead) begin
      st_pend <= 1'b1;
      st_cnt  <= stub_lat;
      st_prod <= {4'b0, mul_mult1} * {8'b0, mul_mult2};
    end else if (st_pend) begin
      if (st_cnt > 1) st_cnt <= st_cnt - 1;
      else begin
        st_pend     <= 1'b0;
        mul_res_rdy <= 1'b1;
        mul_res     <= st_prod;
        st_hold     <= stub_hold;
      end
    end else if (mul_res_rdy) begin
      if (st_hold > 1) st_hold <= st_hold - 1;
      else mul_res_rdy <= 1'b0;
    end
  end

  typedef struct {
    int who;
    int a;
    int b;
    int res;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_ops(input int who, input int a, input int b);
    a_in[who*N +: N] = 8'(a);
    b_in[who*M +: M] = 4'(b);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},   32'(ack), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_err"},   32'(err), 0);
    check({tag, "_res"},   32'(res_out), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_drdy"},  32'(mul_data_rdy), 0);
    check({tag, "_mult1"}, 32'(mul_mult1), 0);
    check({tag, "_mult2"}, 32'(mul_mult2), 0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req  = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // Waits for the grant to `who`, then for its completion; lat = negedges from ack to done.
  task automatic do_job(input int who, input int ea, input int eb, input int eres,
                        input bit eerr, input bit drop, output int lat);
    int t;
    t = 0;
    while (ack === '0 && t < 200) begin @(negedge clk); t++; end
    check("ack_seen", 32'(ack !== '0), 1);
    check("ack_onehot", 32'(ack), 1 << who);
    check("ack_drdy", 32'(mul_data_rdy), 1);
    check("ack_mult1", 32'(mul_mult1), ea);
    check("ack_mult2", 32'(mul_mult2), eb);
    check("ack_busy", 32'(busy), 1);
    if (drop) req[who] = 1'b0;
    @(negedge clk);
    t = 1;
    check("ack_pulse", 32'(ack), 0);
    check("drdy_pulse", 32'(mul_data_rdy), 0);
    while (done === '0 && t < 400) begin @(negedge clk); t++; end
    check("done_seen", 32'(done !== '0), 1);
    check("done_onehot", 32'(done), 1 << who);
    check("done_res", 32'(res_out), eres);
    check("done_err", 32'(err), 32'(eerr));
    check("done_busy", 32'(busy), 1);
    lat = t;
    @(negedge clk);
    check("done_pulse", 32'(done), 0);
    check("err_pulse", 32'(err), 0);
    check("res_held", 32'(res_out), eres);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end expected end");
    $fatal(1);
  end

  initial begin
    int lat, n;
    vecs[0] = '{0, 25, 5, 125};
    vecs[1] = '{1, 255, 15, 3825};
    vecs[2] = '{2, 0, 9, 0};
    vecs[3] = '{3, 200, 1, 200};
    vecs[4] = '{2, 128, 2, 256};
    vecs[5] = '{0, 17, 0, 0};

    rstn = 1'b1;
    req  = '0;
    a_in = '0;
    b_in = '0;
    #1 rstn = 1'b0;
    do_reset();

    // Single requests, one at a time.
    foreach (vecs[i]) begin
      set_ops(vecs[i].who, vecs[i].a, vecs[i].b);
      req[vecs[i].who] = 1'b1;
      do_job(vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].res, 1'b0, 1'b1, lat);
      if (i == 0) check("result_latency", 32'(lat), 3);
      check("idle_busy", 32'(busy), 0);
    end

    // All four at once: rotate 0,1,2,3 from the reset pointer.
    do_reset();
    set_ops(0, 16, 10); set_ops(1, 10, 4); set_ops(2, 15, 7); set_ops(3, 215, 9);
    req = 4'b1111;
    do_job(0, 16, 10, 160, 1'b0, 1'b1, lat);  check("gap_busy0", 32'(busy), 0);
    do_job(1, 10, 4, 40, 1'b0, 1'b1, lat);    check("gap_busy1", 32'(busy), 0);
    do_job(2, 15, 7, 105, 1'b0, 1'b1, lat);   check("gap_busy2", 32'(busy), 0);
    do_job(3, 215, 9, 1935, 1'b0, 1'b1, lat); check("gap_busy3", 32'(busy), 0);

    // Fairness: two requesters held high alternate.
    do_reset();
    set_ops(1, 5, 3); set_ops(3, 6, 2);
    req = 4'b1010;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) do_job(1, 5, 3, 15, 1'b0, 1'b0, lat);
      else            do_job(3, 6, 2, 12, 1'b0, 1'b0, lat);
    end
    req = '0;
    repeat (8) @(negedge clk);

    // Watchdog: dead multiplier.
    do_reset();
    stub_dead = 1'b1;
    set_ops(2, 3, 3);
    req[2] = 1'b1;
    do_job(2, 3, 3, 0, 1'b1, 1'b1, lat);
    check("wdog_latency", 32'(lat), TMO + 1);
    check("wdog_idle", 32'(busy), 0);
    stub_dead = 1'b0;

    // Level-style res_rdy: pending req[1] must wait until res_rdy falls.
    do_reset();
    stub_hold = 5;
    set_ops(0, 12, 12); set_ops(1, 9, 3);
    req = 4'b0011;
    do_job(0, 12, 12, 144, 1'b0, 1'b1, lat);
    n = 0;
    while (mul_res_rdy === 1'b1 && n < 20) begin
      check("drain_no_ack", 32'(ack), 0);
      check("drain_no_done", 32'(done), 0);
      @(negedge clk);
      n++;
    end
    check("drain_rdy_fell", 32'(mul_res_rdy), 0);
    do_job(1, 9, 3, 27, 1'b0, 1'b1, lat);
    stub_hold = 1;

    // Reset in the middle of a WAIT.
    do_reset();
    stub_lat = 20;
    set_ops(0, 10, 4);
    req[0] = 1'b1;
    n = 0;
    while (ack === '0 && n < 50) begin @(negedge clk); n++; end
    check("mid_ack", 32'(ack), 1);
    req[0] = 1'b0;
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    check_reset_outputs("async");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_done", 32'(done), 0);
    end
    rstn = 1'b1;
    stub_lat = 2;
    set_ops(0, 7, 2);
    req[0] = 1'b1;
    do_job(0, 7, 2, 14, 1'b0, 1'b1, lat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
